// File: rtl/gd_pkg.sv
// Shared definitions for the gradient-descent controller: state encoding,
// Q24.8 limits and status flag positions.
package gd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } gd_state_e;

    localparam logic signed [31:0] Q_MAX     = 32'sh7FFFFFFF;
    localparam logic signed [31:0] Q_MIN     = 32'sh80000000;
    localparam int                 FRAC_BITS = 8;

    localparam int FLG_CONVERGED = 0;
    localparam int FLG_OVERFLOW  = 1;
    localparam int FLG_TIMEOUT   = 2;
    localparam int FLG_SATURATED = 3;
    localparam int NUM_FLAGS     = 4;

endpackage

// File: rtl/grad_descent_ctrl_sat_sub.sv
// Saturating Q24.8 subtractor: diff = clamp(a - b), sat flags a clip.
// Also used with a = 0 to form a saturated negation for |x|.
module sat_sub_q24_8
    import gd_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] diff,
    output logic               sat
);

    logic signed [32:0] wide;

    // The two top bits of the 33-bit difference disagree only when the
    // result does not fit in 32 bits; the top bit gives the direction.
    function automatic logic signed [31:0] clamp_q(input logic signed [32:0] w);
        if (w[32] != w[31]) begin
            return w[32] ? Q_MIN : Q_MAX;
        end
        return w[31:0];
    endfunction

    // Full-precision difference, then clamp to the Q24.8 range.
    always_comb begin
        wide = $signed({a[31], a}) - $signed({b[31], b});
        diff = clamp_q(wide);
        sat  = (wide[32] != wide[31]);
    end

endmodule

// File: rtl/grad_descent_ctrl.sv
// Gradient-descent run controller: issues x to the evaluator, applies the
// returned step with saturation and stops on convergence, iteration limit,
// evaluator overflow or evaluator timeout.
module grad_descent_ctrl
    import gd_pkg::*;
#(
    parameter int          MAX_ITER    = 256,
    parameter logic [31:0] TOL         = 32'h00000004,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] x_init,
    output logic        start_func,
    output logic [31:0] x_out,
    input  logic        func_done_in,
    input  logic [31:0] x_diff_in,
    input  logic [63:0] value_in,
    input  logic        overflow_in,
    output logic [31:0] x_final,
    output logic [63:0] value_final,
    output logic [15:0] iter_count,
    output logic        busy,
    output logic        done,
    output logic        converged,
    output logic        err_overflow,
    output logic        timeout,
    output logic        saturated
);

    localparam int              WC_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WC_W-1:0] WC_LAST    = WC_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]     MAX_ITER_W = 16'(MAX_ITER);

    gd_state_e                state_q, state_d;
    logic signed [31:0]       x_reg_q, x_reg_d;
    logic [15:0]              iter_q, iter_d;
    logic [WC_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic signed [31:0]       xdiff_cap_q, xdiff_cap_d;
    logic signed [63:0]       value_cap_q, value_cap_d;
    logic                     ovf_cap_q, ovf_cap_d;
    logic [NUM_FLAGS-1:0]     flags_q, flags_d;
    logic                     start_func_q, start_func_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic [31:0]              x_final_q, x_final_d;
    logic [63:0]              value_final_q, value_final_d;
    logic [15:0]              iter_count_q, iter_count_d;

    logic signed [31:0]       x_next;
    logic                     x_next_sat;
    logic signed [31:0]       neg_diff;
    logic                     neg_sat;
    logic signed [31:0]       abs_x_diff;

    // Candidate next x from the captured step.
    sat_sub_q24_8 u_step (
        .a    (x_reg_q),
        .b    (xdiff_cap_q),
        .diff (x_next),
        .sat  (x_next_sat)
    );

    // Saturated negation of the step; -(0x80000000) lands on Q_MAX.
    sat_sub_q24_8 u_neg (
        .a    (32'sd0),
        .b    (xdiff_cap_q),
        .diff (neg_diff),
        .sat  (neg_sat)
    );

    // Magnitude of the captured step for the convergence test.
    always_comb begin
        abs_x_diff = xdiff_cap_q;
        if (xdiff_cap_q[31]) begin
            abs_x_diff = neg_sat ? Q_MAX : neg_diff;
        end
    end

    // Next-state and datapath update; abort freezes everything but the state.
    always_comb begin
        state_d       = state_q;
        x_reg_d       = x_reg_q;
        iter_d        = iter_q;
        wait_cnt_d    = wait_cnt_q;
        xdiff_cap_d   = xdiff_cap_q;
        value_cap_d   = value_cap_q;
        ovf_cap_d     = ovf_cap_q;
        flags_d       = flags_q;
        x_final_d     = x_final_q;
        value_final_d = value_final_q;
        iter_count_d  = iter_count_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_reg_d = x_init;
                        iter_d  = 16'd0;
                        flags_d = '0;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (func_done_in) begin
                        xdiff_cap_d = x_diff_in;
                        value_cap_d = value_in;
                        ovf_cap_d   = overflow_in;
                        state_d     = ST_UPDATE;
                    end else if (wait_cnt_q == WC_LAST) begin
                        flags_d[FLG_TIMEOUT] = 1'b1;
                        state_d              = ST_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                ST_UPDATE: begin
                    iter_d        = iter_q + 16'd1;
                    value_final_d = value_cap_q;
                    if (ovf_cap_q) begin
                        flags_d[FLG_OVERFLOW] = 1'b1;
                        state_d               = ST_DONE;
                    end else begin
                        x_reg_d = x_next;
                        if (x_next_sat) begin
                            flags_d[FLG_SATURATED] = 1'b1;
                        end
                        if ($unsigned(abs_x_diff) <= TOL) begin
                            flags_d[FLG_CONVERGED] = 1'b1;
                            state_d                = ST_DONE;
                        end else if (iter_d == MAX_ITER_W) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Results become visible together with the done pulse.
            if (state_d == ST_DONE) begin
                x_final_d    = x_reg_d;
                iter_count_d = iter_d;
            end
        end

        start_func_d = (state_d == ST_ISSUE);
        done_d       = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            x_reg_q       <= '0;
            iter_q        <= '0;
            wait_cnt_q    <= '0;
            xdiff_cap_q   <= '0;
            value_cap_q   <= '0;
            ovf_cap_q     <= 1'b0;
            flags_q       <= '0;
            start_func_q  <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            x_final_q     <= '0;
            value_final_q <= '0;
            iter_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            x_reg_q       <= x_reg_d;
            iter_q        <= iter_d;
            wait_cnt_q    <= wait_cnt_d;
            xdiff_cap_q   <= xdiff_cap_d;
            value_cap_q   <= value_cap_d;
            ovf_cap_q     <= ovf_cap_d;
            flags_q       <= flags_d;
            start_func_q  <= start_func_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            x_final_q     <= x_final_d;
            value_final_q <= value_final_d;
            iter_count_q  <= iter_count_d;
        end
    end

    assign start_func   = start_func_q;
    assign x_out        = x_reg_q;
    assign x_final      = x_final_q;
    assign value_final  = value_final_q;
    assign iter_count   = iter_count_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign converged    = flags_q[FLG_CONVERGED];
    assign err_overflow = flags_q[FLG_OVERFLOW];
    assign timeout      = flags_q[FLG_TIMEOUT];
    assign saturated    = flags_q[FLG_SATURATED];

endmodule
